// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX instructions in, stall/flush and mult/div status out.
// The pipeline drives through the master modport; hazard_ctrl attaches through the slave modport.
interface hazard_ctrl_if;
    logic [31:0] instrD;
    logic [31:0] instrE;
    logic        stallF;
    logic        stallD;
    logic        flushE;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output instrD, instrE,
        input  stallF, stallD, flushE, md_start, md_busy, stall_cnt
    );

    modport slave (
        input  instrD, instrE,
        output stallF, stallD, flushE, md_start, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use and mult/div hazard detection for the five-stage MIPS core.
// It also drives the IF/ID/EX hold-flush controls and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCNT_W  = 32;
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0] op_d, op_e;
    logic [3:0] funct_hi_d, funct_hi_e;
    logic       funct_div_e;
    logic [4:0] rs_d, rt_d, rt_e;

    logic reads_rs, reads_rt, load_e, lu;
    logic md_op_e, hilo_op_d, md_busy;
    logic md_start_c, stall_c;
    logic unused_bits;

    assign op_d        = bus.instrD[31:26];
    assign rs_d        = bus.instrD[25:21];
    assign rt_d        = bus.instrD[20:16];
    assign funct_hi_d  = bus.instrD[5:2];
    assign op_e        = bus.instrE[31:26];
    assign rt_e        = bus.instrE[20:16];
    assign funct_hi_e  = bus.instrE[5:2];
    assign funct_div_e = bus.instrE[1];
    assign unused_bits = ^{bus.instrD[15:6], bus.instrD[1:0],
                           bus.instrE[25:21], bus.instrE[15:6], bus.instrE[0]};

    // Load-use: ID reads the register an EX-stage load is about to write
    always_comb begin
        reads_rs = !((op_d == OP_J) || (op_d == OP_JAL) || (op_d == OP_LUI));
        reads_rt = (op_d == OP_RTYPE) || (op_d == OP_BEQ) || (op_d == OP_BNE) ||
                   (op_d[5:3] == 3'b101);
        load_e   = (op_e == OP_LB) || (op_e == OP_LH) || (op_e == OP_LW) ||
                   (op_e == OP_LBU) || (op_e == OP_LHU);
        lu       = load_e && (rt_e != 5'd0) &&
                   ((reads_rs && (rs_d == rt_e)) || (reads_rt && (rt_d == rt_e)));
    end

    // mult/multu/div/divu = funct 0110xx; mfhi/mthi/mflo/mtlo = funct 0100xx
    always_comb begin
        md_op_e   = (op_e == OP_RTYPE) && (funct_hi_e == 4'b0110);
        hilo_op_d = (op_d == OP_RTYPE) &&
                    ((funct_hi_d == 4'b0110) || (funct_hi_d == 4'b0100));
    end

    assign md_busy = (state_q == BUSY);

    // Mult/div occupancy FSM; a start while BUSY is ignored
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_op_e && !reset) begin
                    md_start_c = 1'b1;
                    state_d    = BUSY;
                    cnt_d      = funct_div_e ? DIV_N : MULT_N;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // Single merged stall; the counter saturates at all-ones
    always_comb begin
        stall_c     = !reset && (lu || (hilo_op_d && (md_start_c || md_busy)));
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {SCNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stallF    = stall_c;
    assign bus.stallD    = stall_c;
    assign bus.flushE    = stall_c;
    assign bus.md_start  = md_start_c;
    assign bus.md_busy   = md_busy;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: hand-computed control vectors checked cycle by cycle.
// ctl = {stallF, stallD, flushE, md_start, md_busy}.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    hazard_ctrl_if bus();

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_LW    = 32'h8D28_0000;
    localparam logic [31:0] I_LW0   = 32'h8C00_0000;
    localparam logic [31:0] I_ADD   = 32'h010B_5020;
    localparam logic [31:0] I_ADD0  = 32'h0000_5020;
    localparam logic [31:0] I_SW    = 32'hAD28_0000;
    localparam logic [31:0] I_LUI   = 32'h3C08_1234;
    localparam logic [31:0] I_J     = 32'h0900_0000;
    localparam logic [31:0] I_MULT  = 32'h0109_0018;
    localparam logic [31:0] I_DIV   = 32'h0109_001A;
    localparam logic [31:0] I_MFLO  = 32'h0000_5012;
    localparam logic [31:0] I_MFHI  = 32'h0000_5010;
    localparam logic [31:0] I_MTHI8 = 32'h0100_0011;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_cnt;
    logic [4:0]  ctl;
    logic [4:0]  exp_ctl;

    assign ctl = {bus.stallF, bus.stallD, bus.flushE, bus.md_start, bus.md_busy};

    task automatic set_in(input logic [31:0] d, input logic [31:0] e);
        bus.instrD = d;
        bus.instrE = e;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(I_MFLO, I_MULT);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_total++;
            if (ctl !== 5'b00000) $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, ctl, 5'b00000);
            else n_pass++;
            next_cycle();
        end
        reset = 1'b0;
        set_in(I_NOP, I_NOP);
        settle();
        n_total++;
        if (bus.md_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.md_busy);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", bus.stall_cnt);
        else n_pass++;
        exp_cnt = 32'd0;
        next_cycle();
    endtask

    task automatic test_load_use();
        set_in(I_ADD, I_LW);
        settle();
        n_total++;
        if (ctl !== 5'b11100) $display("FAIL lu_rs got=%b exp=%b", ctl, 5'b11100);
        else n_pass++;
        next_cycle();
        exp_cnt++;
        set_in(I_ADD, I_NOP);
        settle();
        n_total++;
        if (ctl !== 5'b00000) $display("FAIL lu_release got=%b exp=%b", ctl, 5'b00000);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL lu_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        next_cycle();
        set_in(I_SW, I_LW);
        settle();
        n_total++;
        if (ctl !== 5'b11100) $display("FAIL lu_store_rt got=%b exp=%b", ctl, 5'b11100);
        else n_pass++;
        next_cycle();
        exp_cnt++;
    endtask

    task automatic test_no_false();
        logic [31:0] dv [5];
        logic [31:0] ev [5];
        dv = '{I_ADD0, I_LUI, I_J, I_MFLO, I_ADD};
        ev = '{I_LW0,  I_LW,  I_LW, I_NOP, I_NOP};
        for (int i = 0; i < 5; i++) begin
            set_in(dv[i], ev[i]);
            settle();
            n_total++;
            if (ctl !== 5'b00000) $display("FAIL no_false[%0d] got=%b exp=%b", i, ctl, 5'b00000);
            else n_pass++;
            next_cycle();
        end
        settle();
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL no_false_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_mult_mflo();
        next_cycle();
        set_in(I_MFLO, I_MULT);
        settle();
        n_total++;
        if (ctl !== 5'b11110) $display("FAIL mult_start got=%b exp=%b", ctl, 5'b11110);
        else n_pass++;
        next_cycle();
        exp_cnt++;
        for (int i = 1; i <= 5; i++) begin
            set_in(I_MFLO, I_NOP);
            settle();
            n_total++;
            if (ctl !== 5'b11101) $display("FAIL mult_busy[T+%0d] got=%b exp=%b", i, ctl, 5'b11101);
            else n_pass++;
            next_cycle();
            exp_cnt++;
        end
        set_in(I_MFLO, I_NOP);
        settle();
        n_total++;
        if (ctl !== 5'b00000) $display("FAIL mult_release got=%b exp=%b", ctl, 5'b00000);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL mult_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_div();
        set_in(I_NOP, I_DIV);
        settle();
        n_total++;
        if (ctl !== 5'b00010) $display("FAIL div_start got=%b exp=%b", ctl, 5'b00010);
        else n_pass++;
        next_cycle();
        for (int i = 1; i <= 10; i++) begin
            set_in((i == 10) ? I_MFHI : I_NOP, (i == 2) ? I_MULT : I_NOP);
            exp_ctl = (i == 10) ? 5'b11101 : 5'b00001;
            settle();
            n_total++;
            if (ctl !== exp_ctl) $display("FAIL div_busy[T+%0d] got=%b exp=%b", i, ctl, exp_ctl);
            else n_pass++;
            next_cycle();
            if (i == 10) exp_cnt++;
        end
        set_in(I_MFHI, I_NOP);
        settle();
        n_total++;
        if (ctl !== 5'b00000) $display("FAIL div_release got=%b exp=%b", ctl, 5'b00000);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL div_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_combined();
        set_in(I_MTHI8, I_MULT);
        settle();
        n_total++;
        if (ctl !== 5'b11110) $display("FAIL comb_start got=%b exp=%b", ctl, 5'b11110);
        else n_pass++;
        next_cycle();
        exp_cnt++;
        set_in(I_MTHI8, I_LW);
        settle();
        n_total++;
        if (ctl !== 5'b11101) $display("FAIL comb_lu_md got=%b exp=%b", ctl, 5'b11101);
        else n_pass++;
        next_cycle();
        exp_cnt++;
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL comb_cnt_once got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            set_in(I_MTHI8, I_NOP);
            next_cycle();
            exp_cnt++;
        end
        set_in(I_MTHI8, I_NOP);
        settle();
        n_total++;
        if (ctl !== 5'b00000) $display("FAIL comb_release got=%b exp=%b", ctl, 5'b00000);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL comb_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_busy();
        set_in(I_MFLO, I_DIV);
        settle();
        n_total++;
        if (ctl !== 5'b11110) $display("FAIL rmb_start got=%b exp=%b", ctl, 5'b11110);
        else n_pass++;
        next_cycle();
        for (int i = 1; i <= 3; i++) begin
            set_in(I_MFLO, I_NOP);
            next_cycle();
        end
        reset = 1'b1;
        set_in(I_MFLO, I_NOP);
        settle();
        n_total++;
        if (ctl !== 5'b00001) $display("FAIL rmb_in_reset got=%b exp=%b", ctl, 5'b00001);
        else n_pass++;
        next_cycle();
        reset = 1'b0;
        exp_cnt = 32'd0;
        for (int i = 5; i <= 6; i++) begin
            set_in(I_MFLO, I_NOP);
            settle();
            n_total++;
            if (ctl !== 5'b00000) $display("FAIL rmb_after[T+%0d] got=%b exp=%b", i, ctl, 5'b00000);
            else n_pass++;
            next_cycle();
        end
        settle();
        n_total++;
        if (bus.stall_cnt !== exp_cnt) $display("FAIL rmb_cnt got=%h exp=%h", bus.stall_cnt, exp_cnt);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_saturation();
        set_in(I_NOP, I_NOP);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        release dut.stall_cnt_q;
        settle();
        n_total++;
        if (bus.stall_cnt !== 32'hFFFF_FFFE) $display("FAIL sat_preload got=%h exp=%h", bus.stall_cnt, 32'hFFFF_FFFE);
        else n_pass++;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(I_ADD, I_LW);
            next_cycle();
            settle();
            n_total++;
            if (bus.stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_hold[%0d] got=%h exp=%h", i, bus.stall_cnt, 32'hFFFF_FFFF);
            else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false();
        test_mult_mflo();
        test_div();
        test_combined();
        test_reset_mid_busy();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It inspects the instructions held in the ID stage (`instrD`) and EX stage (`instrE`) and detects load-use hazards. It also sequences the multi-cycle multiply/divide resource with an internal busy FSM. From these it drives the hold/flush controls for the PC, the IF/ID register and the ID/EX register, whose `stall` input clears its outputs to a bubble. It also keeps a saturating count of stall cycles for performance debug.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu leaves EX.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu leaves EX.
- Both parameters must be at least 1 and at most 255.

- `clk` (in, 1): single clock; all state updates on its rising edge.
- `reset` (in, 1): synchronous, active-high reset.
- `instrD` (in, 32): instruction currently in ID.
- `instrE` (in, 32): instruction currently in EX. A bubble is `32'h0`.
- `stallF` (out, 1): hold the PC.
- `stallD` (out, 1): hold the IF/ID register.
- `flushE` (out, 1): load a bubble into ID/EX; connects to that register's `stall` input.
- `md_start` (out, 1): one-cycle pulse launching the mult/div unit on the EX instruction.
- `md_busy` (out, 1): mult/div unit occupied; HI/LO not yet valid.
- `stall_cnt` (out, 32): number of cycles in which `stallF` was asserted, saturating.

## Operation
Decode fields: `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `funct=[5:0]`.

Source usage of ID:
- ID reads rs unless op is j (000010), jal (000011) or lui (001111).
- ID reads rt if op is 000000, beq (000100), bne (000101), or any store (op[5:3]=101).

Load-use hazard (`lu`):
- EX op is lb, lh, lw, lbu or lhu (100000, 100001, 100011, 100100, 100101), and EX rt ≠ 0.
- Hazard when (ID reads rs and rsD = rtE) or (ID reads rt and rtD = rtE).

Mult/div instruction classes:
- `md_op`: op = 0 and funct in {011000, 011001, 011010, 011011}.
- `hilo_op`: `md_op`, or op = 0 and funct in {mfhi 010000, mthi 010001, mflo 010010, mtlo 010011}.

Mult/div FSM, states IDLE and BUSY, 8-bit down-counter `cnt`:
- `md_start` = (state = IDLE) and `instrE` is `md_op`. It is combinational.
- On a clock edge with `md_start`: go to BUSY and set `cnt` = `MULT_CYCLES` (funct[1]=0) or `DIV_CYCLES` (funct[1]=1).
- In BUSY: `cnt` decrements each cycle. When `cnt` = 1, return to IDLE with `cnt` = 0.
- An `md_op` in EX while the state is BUSY is ignored: no restart, no `md_start`. This cannot occur in legal operation, because the stall below prevents it.
- `md_busy` = (state = BUSY).
- `md` stall = `instrD` is `hilo_op` and (`md_start` or `md_busy`).

Stall outputs:
- `stall` = `lu` or `md`.
- `stallF` = `stallD` = `flushE` = `stall`.
- While `reset` is high, all three stall outputs and `md_start` are forced to 0.

Stall counter:
- `stall_cnt` increments on each edge where `stallF` = 1.
- It holds at `32'hFFFF_FFFF` once it reaches that value.

## Timing
- Reset (synchronous): state = IDLE, `cnt` = 0, `md_busy` = 0, `stall_cnt` = 0.
- Reset takes priority over every other event, including a reset asserted mid-BUSY, which returns to IDLE on that edge.
- Stall and start outputs are combinational from `instrD`, `instrE` and state, with zero latency. They are valid in the same cycle the instructions appear.
- Load-use costs exactly 1 stall cycle. After the bubble enters EX, `lu` clears.
- Mult/div: the start cycle is T, the cycle in which the `md_op` sits in EX. `md_busy` is high in cycles T+1 through T+N, where N is the selected parameter. A `hilo_op` in ID is stalled in cycles T through T+N and proceeds in T+N+1.
- Load-use and mult/div hazards occurring together produce a single `stall`. `stall_cnt` counts that cycle once.
- An `instrE` of `32'h0` (bubble, decodes as sll $0) never causes a hazard.

## Test plan
- Reset: hold `reset` for 2 cycles with `instrE` = `0x01090018` (mult). Required: `md_start` = 0 and all stalls = 0 throughout; after release, `md_busy` = 0 and `stall_cnt` = 0.
- Load-use: `instrE` = `0x8D280000` (lw $8,0($9)), `instrD` = `0x010B5020` (add $10,$8,$11). Required: stallF/stallD/flushE = 1 for one cycle. Next cycle, with `instrE` = 0: all 0 and `stall_cnt` = 1.
- No false hazard:
  - `instrE` = `0x8C000000` (lw $0), `instrD` = `0x00005020` (add $10,$0,$0). Required: no stall.
  - `instrE` = `0x8D280000`, `instrD` = `0x3C081234` (lui $8). Required: no stall.
- Mult then mflo: `instrE` = `0x01090018`, `instrD` = `0x00005012`. Required: `md_start` = 1 in cycle T; `md_busy` = 1 in T+1..T+5; stall in T..T+5 (6 cycles); released in T+6; `stall_cnt` = 6.
- Div with reset mid-BUSY: `instrE` = `0x0109001A`. Required: `md_busy` = 1 for 10 cycles. In a second run, assert `reset` at T+4: `md_busy` = 0 from T+5, with no residual stall.
- Saturation: count 2^32 − 1 stall cycles, or preload via force. Required: further stalls keep `stall_cnt` = `FFFF_FFFF`.
